// File: rtl/op_logic_pkg.sv
// Shared encodings for the logic-group execute pipe and its operand-2 shifter.
// Opcode, shift-type and flag-bit positions live here so the arithmetic unit can reuse them.
package op_logic_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_EOR = 3'b001,
        OP_ORR = 3'b010,
        OP_BIC = 3'b011,
        OP_MOV = 3'b100,
        OP_MVN = 3'b101,
        OP_TST = 3'b110,
        OP_TEQ = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_LSL = 2'b00,
        ST_LSR = 2'b01,
        ST_ASR = 2'b10,
        ST_ROR = 2'b11
    } stype_e;

    localparam int FLG_N = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_C = 0;

    function automatic logic op_writes_rd(input op_e op);
        return !(op == OP_TST || op == OP_TEQ);
    endfunction

endpackage

// File: rtl/barrel_shifter_c.sv
// Combinational operand-2 barrel shifter with ARM carry-out semantics, including RRX.
// Zero latency; no flow control of its own.
module barrel_shifter_c
    import op_logic_pkg::*;
#(
    parameter int DW  = 32,
    parameter int SHW = $clog2(DW),
    parameter int AW  = (SHW > 8) ? SHW : 8
) (
    input  logic [DW-1:0] rm_i,
    input  stype_e        stype_i,
    input  logic [AW-1:0] amount_i,
    input  logic          reg_shift_i,
    input  logic          cin_i,
    output logic [DW-1:0] op2_o,
    output logic          shc_o
);

    localparam int XW = AW + 1;
    localparam logic [XW-1:0] DWX = XW'(DW);

    logic [XW-1:0]  amt;
    logic           rrx;
    logic [SHW-1:0] rot_amt;
    logic [DW-1:0]  rot;

    function automatic logic bit_at(input logic [DW-1:0] v, input logic [XW-1:0] idx);
        logic [DW-1:0] t;
        t = v >> idx;
        return t[0];
    endfunction

    // Immediate #0 is overloaded: LSR/ASR mean a full-width shift, ROR means RRX.
    always_comb begin
        amt = {1'b0, amount_i};
        rrx = 1'b0;
        if (!reg_shift_i && amount_i == '0) begin
            if (stype_i == ST_LSR || stype_i == ST_ASR) amt = DWX;
            else if (stype_i == ST_ROR)                 rrx = 1'b1;
        end
    end

    assign rot_amt = amt[SHW-1:0];
    assign rot     = (rm_i >> rot_amt) | (rm_i << (DWX - XW'(rot_amt)));

    always_comb begin
        op2_o = rm_i;
        shc_o = cin_i;
        if (rrx) begin
            op2_o = {cin_i, rm_i[DW-1:1]};
            shc_o = rm_i[0];
        end else if (amt != '0) begin
            case (stype_i)
                ST_LSL: begin
                    if (amt < DWX) begin
                        op2_o = rm_i << amt;
                        shc_o = bit_at(rm_i, DWX - amt);
                    end else begin
                        op2_o = '0;
                        shc_o = (amt == DWX) && rm_i[0];
                    end
                end
                ST_LSR: begin
                    if (amt < DWX) begin
                        op2_o = rm_i >> amt;
                        shc_o = bit_at(rm_i, amt - 1'b1);
                    end else begin
                        op2_o = '0;
                        shc_o = (amt == DWX) && rm_i[DW-1];
                    end
                end
                ST_ASR: begin
                    if (amt < DWX) begin
                        op2_o = $signed(rm_i) >>> amt;
                        shc_o = bit_at(rm_i, amt - 1'b1);
                    end else begin
                        op2_o = {DW{rm_i[DW-1]}};
                        shc_o = rm_i[DW-1];
                    end
                end
                // A multiple of DW rotates back to rm, so rot[DW-1] is already rm[DW-1].
                ST_ROR: begin
                    op2_o = rot;
                    shc_o = rot[DW-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/op_logic_pipe.sv
// Two-stage valid/ready logic-group execute unit owning the N/Z/C register.
// Result two edges after accept; stalls hold outputs and back-pressure in_ready.
module op_logic_pipe
    import op_logic_pkg::*;
#(
    parameter int DW   = 32,
    parameter int SHW  = $clog2(DW),
    parameter int IMMW = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_s,
    input  logic            in_imm,
    input  logic [IMMW-1:0] in_imm_val,
    input  logic [DW-1:0]   in_rn,
    input  logic [DW-1:0]   in_rm,
    input  logic [1:0]      in_stype,
    input  logic            in_reg_shift,
    input  logic [SHW-1:0]  in_imm_shift,
    input  logic [7:0]      in_rs,
    input  logic            flag_load,
    input  logic [2:0]      flag_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_rd,
    output logic            out_wr,
    output logic [2:0]      out_flags,
    output logic [2:0]      flags_q
);

    localparam int AW = (SHW > 8) ? SHW : 8;

    logic          adv1, adv2;
    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_op2_q, s1_op2_d;
    logic [DW-1:0] s1_rn_q, s1_rn_d;
    logic          s1_shc_q, s1_shc_d;
    op_e           s1_op_q, s1_op_d;
    logic          s1_s_q, s1_s_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_rd_q, out_rd_d;
    logic          out_wr_q, out_wr_d;
    logic [2:0]    out_flags_q, out_flags_d;
    logic [2:0]    flags_d;

    logic          cin;
    logic [AW-1:0] sh_amount;
    logic [DW-1:0] sh_op2, op2, res;
    logic          sh_shc, shc;
    logic [2:0]    nzc;

    assign adv2     = (out_valid_q & out_ready) | ~out_valid_q;
    assign adv1     = adv2 | ~s1_valid_q;
    assign in_ready = adv1;

    // An S-op still in stage 1 has not written flags_q yet, so its carry is forwarded.
    assign cin       = (s1_valid_q & s1_s_q) ? s1_shc_q : flags_q[FLG_C];
    assign sh_amount = in_reg_shift ? AW'(in_rs) : AW'(in_imm_shift);

    barrel_shifter_c #(.DW(DW), .SHW(SHW), .AW(AW)) u_shift (
        .rm_i        (in_rm),
        .stype_i     (stype_e'(in_stype)),
        .amount_i    (sh_amount),
        .reg_shift_i (in_reg_shift),
        .cin_i       (cin),
        .op2_o       (sh_op2),
        .shc_o       (sh_shc)
    );

    assign op2 = in_imm ? DW'(in_imm_val) : sh_op2;
    assign shc = in_imm ? cin : sh_shc;

    always_comb begin
        res = '0;
        case (s1_op_q)
            OP_AND, OP_TST: res = s1_rn_q & s1_op2_q;
            OP_EOR, OP_TEQ: res = s1_rn_q ^ s1_op2_q;
            OP_ORR:         res = s1_rn_q | s1_op2_q;
            OP_BIC:         res = s1_rn_q & ~s1_op2_q;
            OP_MOV:         res = s1_op2_q;
            OP_MVN:         res = ~s1_op2_q;
        endcase
        nzc        = '0;
        nzc[FLG_N] = res[DW-1];
        nzc[FLG_Z] = (res == '0);
        nzc[FLG_C] = s1_shc_q;
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op2_d    = s1_op2_q;
        s1_rn_d     = s1_rn_q;
        s1_shc_d    = s1_shc_q;
        s1_op_d     = s1_op_q;
        s1_s_d      = s1_s_q;
        out_valid_d = out_valid_q;
        out_rd_d    = out_rd_q;
        out_wr_d    = out_wr_q;
        out_flags_d = out_flags_q;
        flags_d     = flags_q;

        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op2_d = op2;
                s1_rn_d  = in_rn;
                s1_shc_d = shc;
                s1_op_d  = op_e'(in_op);
                s1_s_d   = in_s;
            end
        end

        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_rd_d    = res;
                out_wr_d    = op_writes_rd(s1_op_q);
                out_flags_d = s1_s_q ? nzc : flags_q;
            end
        end

        if (adv2 && s1_valid_q && s1_s_q) flags_d = nzc;
        else if (flag_load)               flags_d = flag_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op2_q    <= '0;
            s1_rn_q     <= '0;
            s1_shc_q    <= 1'b0;
            s1_op_q     <= OP_AND;
            s1_s_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_wr_q    <= 1'b0;
            out_flags_q <= '0;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op2_q    <= s1_op2_d;
            s1_rn_q     <= s1_rn_d;
            s1_shc_q    <= s1_shc_d;
            s1_op_q     <= s1_op_d;
            s1_s_q      <= s1_s_d;
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_wr_q    <= out_wr_d;
            out_flags_q <= out_flags_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_rd    = out_rd_q;
    assign out_wr    = out_wr_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_op_logic_pipe.sv
// Bench for op_logic_pipe: directed scenarios plus randomized traffic against a
// sequential architectural model (bit-at-a-time shifting, program-order flags).
module tb_op_logic_pipe;

    localparam int DW   = 32;
    localparam int SHW  = 5;
    localparam int IMMW = 12;

    localparam logic [2:0] O_AND = 3'd0, O_EOR = 3'd1, O_ORR = 3'd2, O_BIC = 3'd3;
    localparam logic [2:0] O_MOV = 3'd4, O_MVN = 3'd5, O_TST = 3'd6, O_TEQ = 3'd7;
    localparam logic [1:0] S_LSL = 2'd0, S_LSR = 2'd1, S_ASR = 2'd2, S_ROR = 2'd3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready;
    logic [2:0]      in_op;
    logic            in_s, in_imm;
    logic [IMMW-1:0] in_imm_val;
    logic [DW-1:0]   in_rn, in_rm;
    logic [1:0]      in_stype;
    logic            in_reg_shift;
    logic [SHW-1:0]  in_imm_shift;
    logic [7:0]      in_rs;
    logic            flag_load;
    logic [2:0]      flag_in;
    logic            out_valid, out_ready;
    logic [DW-1:0]   out_rd;
    logic            out_wr;
    logic [2:0]      out_flags, flags_q;

    always #5 clk = ~clk;

    op_logic_pipe #(.DW(DW), .SHW(SHW), .IMMW(IMMW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_s(in_s),
        .in_imm(in_imm), .in_imm_val(in_imm_val), .in_rn(in_rn), .in_rm(in_rm),
        .in_stype(in_stype), .in_reg_shift(in_reg_shift), .in_imm_shift(in_imm_shift),
        .in_rs(in_rs), .flag_load(flag_load), .flag_in(flag_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_wr(out_wr),
        .out_flags(out_flags), .flags_q(flags_q)
    );

    typedef struct {
        logic [2:0]  op;
        logic        s;
        logic        imm;
        logic [11:0] imm_val;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [1:0]  stype;
        logic        reg_shift;
        logic [4:0]  imm_shift;
        logic [7:0]  rs;
    } op_t;

    typedef struct {
        logic [31:0] rd;
        logic        wr;
        logic [2:0]  flags;
    } res_t;

    int   vec_cnt  = 0;
    int   miss_cnt = 0;
    res_t exp_q[$];
    res_t got_q[$];
    res_t last_got[$];
    res_t mon_r;
    logic [2:0] mflags = 3'b000;
    bit   rnd_done;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            mon_r.rd    = out_rd;
            mon_r.wr    = out_wr;
            mon_r.flags = out_flags;
            got_q.push_back(mon_r);
        end
    end

    function automatic op_t mk(input logic [2:0] op, input logic s, input logic imm,
                               input logic [11:0] iv, input logic [31:0] rn, input logic [31:0] rm,
                               input logic [1:0] st, input logic rsh, input logic [4:0] ish,
                               input logic [7:0] rs);
        op_t o;
        o.op = op; o.s = s; o.imm = imm; o.imm_val = iv; o.rn = rn; o.rm = rm;
        o.stype = st; o.reg_shift = rsh; o.imm_shift = ish; o.rs = rs;
        return o;
    endfunction

    // Architectural reference: shift one bit at a time, carry is the last bit shifted out.
    function automatic void model_push(input op_t o);
        logic [31:0] x, op2, res;
        logic        c;
        int          n;
        res_t        e;
        logic [2:0]  nf;
        c = mflags[0];
        x = o.rm;
        if (o.imm) begin
            op2 = {20'd0, o.imm_val};
        end else begin
            n = o.reg_shift ? int'(o.rs) : int'(o.imm_shift);
            if (!o.reg_shift && n == 0 && (o.stype == S_LSR || o.stype == S_ASR)) n = 32;
            if (!o.reg_shift && n == 0 && o.stype == S_ROR) begin
                c = x[0];
                x = {mflags[0], x[31:1]};
            end else begin
                for (int i = 0; i < n; i++) begin
                    case (o.stype)
                        S_LSL:   begin c = x[31]; x = x << 1; end
                        S_LSR:   begin c = x[0];  x = x >> 1; end
                        S_ASR:   begin c = x[0];  x = {x[31], x[31:1]}; end
                        default: begin c = x[0];  x = {x[0], x[31:1]}; end
                    endcase
                end
            end
            op2 = x;
        end
        case (o.op)
            O_AND, O_TST: res = o.rn & op2;
            O_EOR, O_TEQ: res = o.rn ^ op2;
            O_ORR:        res = o.rn | op2;
            O_BIC:        res = o.rn & ~op2;
            O_MOV:        res = op2;
            default:      res = ~op2;
        endcase
        nf      = {res[31], (res == 32'd0), c};
        e.rd    = res;
        e.wr    = (o.op != O_TST) && (o.op != O_TEQ);
        e.flags = o.s ? nf : mflags;
        if (o.s) mflags = nf;
        exp_q.push_back(e);
    endfunction

    task automatic set_inputs(input op_t o);
        in_op = o.op; in_s = o.s; in_imm = o.imm; in_imm_val = o.imm_val;
        in_rn = o.rn; in_rm = o.rm; in_stype = o.stype; in_reg_shift = o.reg_shift;
        in_imm_shift = o.imm_shift; in_rs = o.rs;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            vec_cnt++; miss_cnt++;
            $display("FAIL accept_timeout: in_ready=%b required 1 within 300 cycles", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic send(input op_t o);
        set_inputs(o);
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        model_push(o);
    endtask

    task automatic drain(input int n);
        res_t g, e;
        bit   ok = 1'b0;
        last_got.delete();
        for (int t = 0; t < 6000; t++) begin
            if (got_q.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (!ok) begin
            vec_cnt++; miss_cnt++;
            $display("FAIL drain_timeout: got %0d results, required %0d", got_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                g = got_q.pop_front();
                last_got.push_back(g);
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    miss_cnt++;
                    $display("FAIL extra_result: rd=%h with no expected op", g.rd);
                end else begin
                    e = exp_q.pop_front();
                    if (g.rd !== e.rd || g.wr !== e.wr || g.flags !== e.flags) begin
                        miss_cnt++;
                        $display("FAIL result[%0d]: rd=%h wr=%b flags=%b required rd=%h wr=%b flags=%b",
                                 i, g.rd, g.wr, g.flags, e.rd, e.wr, e.flags);
                    end
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic load_flags(input logic [2:0] v);
        flag_load = 1'b1; flag_in = v;
        @(posedge clk); #1;
        flag_load = 1'b0;
        mflags = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_inputs(mk(O_MOV, 1, 1, 12'h5A5, 0, 0, S_LSL, 0, 0, 0));
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || flags_q !== 3'b000) begin
            miss_cnt++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b flags_q=%b required 1 0 000",
                     in_ready, out_valid, flags_q);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (4) @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b0 || got_q.size() != 0) begin
            miss_cnt++;
            $display("FAIL reset_no_accept: out_valid=%b results=%0d required 0 0", out_valid, got_q.size());
        end
        @(posedge clk); #1;
        mflags = 3'b000;
    endtask

    task automatic test_bic_lsl();
        send(mk(O_BIC, 1, 0, 0, 32'hFFFF_FFFF, 32'h0000_00F0, S_LSL, 0, 5'd4, 0));
        @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL bic_early: out_valid=%b one edge after accept, required 0", out_valid);
        end
        @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b1 || out_rd !== 32'hFFFF_F0FF || out_flags !== 3'b100 || out_wr !== 1'b1) begin
            miss_cnt++;
            $display("FAIL bic_result: valid=%b rd=%h flags=%b wr=%b required 1 FFFFF0FF 100 1",
                     out_valid, out_rd, out_flags, out_wr);
        end
        drain(1);
    endtask

    task automatic test_rrx();
        load_flags(3'b001);
        vec_cnt++;
        if (flags_q !== 3'b001) begin
            miss_cnt++;
            $display("FAIL flag_load: flags_q=%b required 001", flags_q);
        end
        send(mk(O_MOV, 1, 0, 0, 0, 32'h0000_0001, S_ROR, 0, 5'd0, 0));
        drain(1);
        vec_cnt++;
        if (last_got.size() != 1 || last_got[0].rd !== 32'h8000_0000 || last_got[0].flags !== 3'b101
            || flags_q !== 3'b101) begin
            miss_cnt++;
            $display("FAIL rrx: rd=%h flags=%b flags_q=%b required 80000000 101 101",
                     last_got.size() > 0 ? last_got[0].rd : 32'hx,
                     last_got.size() > 0 ? last_got[0].flags : 3'bx, flags_q);
        end
    endtask

    task automatic test_reg_lsr();
        send(mk(O_MOV, 1, 0, 0, 0, 32'h8000_0000, S_LSR, 1, 0, 8'd32));
        send(mk(O_MOV, 1, 0, 0, 0, 32'h8000_0000, S_LSR, 1, 0, 8'd33));
        send(mk(O_TST, 1, 0, 0, 32'h0000_000F, 32'h0000_00F0, S_LSL, 0, 5'd0, 0));
        drain(3);
        vec_cnt++;
        if (last_got.size() != 3 || last_got[0].rd !== 32'd0 || last_got[0].flags !== 3'b011) begin
            miss_cnt++;
            $display("FAIL lsr_32: rd=%h flags=%b required 00000000 011",
                     last_got.size() > 0 ? last_got[0].rd : 32'hx, last_got.size() > 0 ? last_got[0].flags : 3'bx);
        end
        vec_cnt++;
        if (last_got.size() != 3 || last_got[1].rd !== 32'd0 || last_got[1].flags !== 3'b010) begin
            miss_cnt++;
            $display("FAIL lsr_33: rd=%h flags=%b required 00000000 010",
                     last_got.size() > 1 ? last_got[1].rd : 32'hx, last_got.size() > 1 ? last_got[1].flags : 3'bx);
        end
        vec_cnt++;
        if (last_got.size() != 3 || last_got[2].wr !== 1'b0 || last_got[2].flags !== 3'b010) begin
            miss_cnt++;
            $display("FAIL tst_zero: wr=%b flags=%b required 0 010",
                     last_got.size() > 2 ? last_got[2].wr : 1'bx, last_got.size() > 2 ? last_got[2].flags : 3'bx);
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] held;
        out_ready = 1'b0;
        send(mk(O_MOV, 0, 1, 12'h111, 0, 0, S_LSL, 0, 0, 0));
        send(mk(O_MOV, 0, 1, 12'h222, 0, 0, S_LSL, 0, 0, 0));
        set_inputs(mk(O_MOV, 0, 1, 12'h333, 0, 0, S_LSL, 0, 0, 0));
        in_valid = 1'b1;
        held = exp_q[0].rd;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== held) begin
                miss_cnt++;
                $display("FAIL stall[%0d]: in_ready=%b out_valid=%b rd=%h required 0 1 %h",
                         i, in_ready, out_valid, out_rd, held);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        model_push(mk(O_MOV, 0, 1, 12'h333, 0, 0, S_LSL, 0, 0, 0));
        drain(3);
        vec_cnt++;
        if (last_got.size() != 3 || last_got[0].rd !== 32'h111 || last_got[1].rd !== 32'h222
            || last_got[2].rd !== 32'h333) begin
            miss_cnt++;
            $display("FAIL stall_order: got %0d results, required 111 222 333 in order", last_got.size());
        end
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (got_q.size() != 0) begin
            miss_cnt++;
            $display("FAIL stall_dup: extra results=%0d required 0", got_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_forward_reset();
        load_flags(3'b000);
        send(mk(O_MOV, 1, 0, 0, 0, 32'h8000_0000, S_LSL, 0, 5'd1, 0));
        send(mk(O_MOV, 0, 0, 0, 0, 32'h0000_0000, S_ROR, 0, 5'd0, 0));
        drain(2);
        vec_cnt++;
        if (last_got.size() != 2 || last_got[0].flags !== 3'b011 || last_got[1].rd !== 32'h8000_0000
            || last_got[1].flags !== 3'b011) begin
            miss_cnt++;
            $display("FAIL carry_forward: rd=%h flags=%b required 80000000 011",
                     last_got.size() > 1 ? last_got[1].rd : 32'hx, last_got.size() > 1 ? last_got[1].flags : 3'bx);
        end
        out_ready = 1'b0;
        send(mk(O_MVN, 1, 1, 12'h000, 0, 0, S_LSL, 0, 0, 0));
        send(mk(O_MOV, 1, 1, 12'h001, 0, 0, S_LSL, 0, 0, 0));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b0 || flags_q !== 3'b000 || in_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL reset_inflight: out_valid=%b flags_q=%b in_ready=%b required 0 000 1",
                     out_valid, flags_q, in_ready);
        end
        exp_q.delete();
        mflags = 3'b000;
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++;
        if (got_q.size() != 0) begin
            miss_cnt++;
            $display("FAIL reset_discard: results after reset=%0d required 0", got_q.size());
        end
    endtask

    task automatic test_random();
        localparam int N = 300;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    logic [31:0] rm;
                    logic [7:0]  rs;
                    case ($urandom_range(0, 5))
                        0:       rm = 32'd0;
                        1:       rm = 32'h8000_0000;
                        default: rm = $urandom;
                    endcase
                    rs = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 40)) : 8'($urandom);
                    if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
                    send(mk(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                            12'($urandom), $urandom, rm, 2'($urandom_range(0, 3)),
                            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rs));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain(N);
        vec_cnt++;
        if (flags_q !== mflags) begin
            miss_cnt++;
            $display("FAIL random_flags: flags_q=%b required %b", flags_q, mflags);
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b1; flag_load = 1'b0; flag_in = 3'b000;
        set_inputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_bic_lsl();
        test_rrx();
        test_reg_lsr();
        test_back_to_back_stall();
        test_forward_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
